// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: bus widths,
// EXE->MEM / MEM->WB bus layouts, access-size encodings and FSM states.
package mem_stage_pkg;

    localparam int REG_W            = 32;
    localparam int REG_ADDR_BUS_W   = 5;
    localparam int EXE2MEM_BUS_SIZE = 107;
    localparam int MEM2WB_BUS_SIZE  = 102;

    // Bit offsets of the EXE->MEM fields (LSB of each field).
    localparam int E2M_PC_LSB     = 0;
    localparam int E2M_SDATA_LSB  = 32;
    localparam int E2M_RESULT_LSB = 64;
    localparam int E2M_SIGN_BIT   = 96;
    localparam int E2M_SIZE_LSB   = 97;
    localparam int E2M_STORE_BIT  = 99;
    localparam int E2M_LOAD_BIT   = 100;
    localparam int E2M_WE_BIT     = 101;
    localparam int E2M_WDEST_LSB  = 102;

    // Access size encodings.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Memory access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    // EXE->MEM register layout, MSB first.
    typedef struct packed {
        logic [REG_ADDR_BUS_W-1:0] wdest;
        logic                      we;
        logic                      is_load;
        logic                      is_store;
        logic [1:0]                size;
        logic                      sign;
        logic [REG_W-1:0]          exe_result;
        logic [REG_W-1:0]          store_data;
        logic [REG_W-1:0]          pc;
    } exe2mem_t;

    // MEM->WB register layout, MSB first.
    typedef struct packed {
        logic [REG_ADDR_BUS_W-1:0] wdest;
        logic                      we;
        logic [REG_W-1:0]          result;
        logic [REG_W-1:0]          dm_addr;
        logic [REG_W-1:0]          pc;
    } mem2wb_t;

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the data memory: builds store strobes and
// lane-replicated write data, and shifts/extends returned load data.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]       size,
    input  logic             sign,
    input  logic [1:0]       addr_lo,
    input  logic [REG_W-1:0] store_data,
    input  logic [REG_W-1:0] rdata,
    output logic [3:0]       strobe,
    output logic [REG_W-1:0] wdata,
    output logic [REG_W-1:0] load_value
);

    logic [REG_W-1:0] shifted;

    // One byte lane per iteration: the lane is enabled when the access
    // covers it, and always carries the store byte that would land there.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign strobe[gi] = (size == SZ_B) ? (addr_lo == LANE) :
                                (size == SZ_H) ? (addr_lo[1] == LANE[1]) :
                                                 1'b1;

            assign wdata[8*gi +: 8] = (size == SZ_B) ? store_data[7:0] :
                                      (size == SZ_H) ? store_data[8*(gi%2) +: 8] :
                                                       store_data[8*gi +: 8];
        end
    endgenerate

    // Bring the addressed byte/halfword down to bit 0.
    assign shifted = rdata >> {addr_lo, 3'b000};

    // Sign- or zero-extend sub-word loads; words pass straight through.
    always_comb begin
        load_value = shifted;
        case (size)
            SZ_B:    load_value = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_value = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: sequences data-memory loads/stores over a req/ready +
// rvalid handshake, produces the stage result and owns the MEM->WB register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic [EXE2MEM_BUS_SIZE-1:0]   exe2mem_bus_ri,
    input  logic                          ctl_mem_valid_i,
    input  logic                          ctl_wb_allowin_i,
    output logic                          ctl_mem_allowin_o,
    output logic                          ctl_mem_over_o,
    output logic [REG_ADDR_BUS_W-1:0]     ctl_mem_dest_o,
    output logic [REG_W-1:0]              ctl_mem_pc_o,
    output logic                          ctl_mem_misalign_o,
    output logic [REG_W-1:0]              forward_mem2id_data_o,
    output logic [MEM2WB_BUS_SIZE-1:0]    mem2wb_bus_o,
    output logic                          ctl_wb_valid_o,

    output logic                          dm_req_o,
    output logic [3:0]                    dm_we_o,
    output logic [REG_W-1:0]              dm_addr_o,
    output logic [REG_W-1:0]              dm_wdata_o,
    input  logic                          dm_ready_i,
    input  logic                          dm_rvalid_i,
    input  logic [REG_W-1:0]              dm_rdata_i
);

    exe2mem_t         ex;
    mem_state_e       state_reg;
    logic [REG_W-1:0] ld_data_reg;
    mem2wb_t          wb_bus_reg;
    logic             wb_valid_reg;

    logic             mem_op;
    logic             misalign;
    logic             fast_path;
    logic             over;
    logic             transfer;
    logic             out_blocked;
    logic             start_req;
    logic             in_req;
    logic [REG_W-1:0] mem_result;

    logic [3:0]       lane_strobe;
    logic [REG_W-1:0] lane_wdata;
    logic [REG_W-1:0] load_value;

    assign ex = exe2mem_bus_ri;

    assign mem_op   = ex.is_load | ex.is_store;
    assign misalign = mem_op & is_misaligned(ex.size, ex.exe_result[1:0]);

    // Non-memory and misaligned instructions finish in the cycle they arrive
    // and never touch the data memory.
    assign fast_path = ctl_mem_valid_i & (~mem_op | misalign);
    assign over      = fast_path | (ctl_mem_valid_i & (state_reg == ST_DONE));
    assign transfer  = over & ctl_wb_allowin_i;

    // The MEM->WB register cannot take new data while WB is stalled on it.
    assign out_blocked = wb_valid_reg & ~ctl_wb_allowin_i;
    assign start_req   = ctl_mem_valid_i & mem_op & ~misalign & ~out_blocked;

    mem_align u_align (
        .size       (ex.size),
        .sign       (ex.sign),
        .addr_lo    (ex.exe_result[1:0]),
        .store_data (ex.store_data),
        .rdata      (dm_rdata_i),
        .strobe     (lane_strobe),
        .wdata      (lane_wdata),
        .load_value (load_value)
    );

    // Stage result: ALU value passes through, faulting and store ops give 0,
    // loads give the captured, already-aligned read data.
    always_comb begin
        mem_result = ex.exe_result;
        if (mem_op) begin
            if (misalign || ex.is_store) begin
                mem_result = '0;
            end else begin
                mem_result = ld_data_reg;
            end
        end
    end

    // Access sequencer: issue one request, wait for read data if needed,
    // then hold the finished instruction until WB accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            ld_data_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_req) begin
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dm_ready_i) begin
                        if (ex.is_load) begin
                            // Read data may come back in the accept cycle.
                            if (dm_rvalid_i) begin
                                ld_data_reg <= load_value;
                                state_reg   <= ST_DONE;
                            end else begin
                                state_reg   <= ST_WAIT;
                            end
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dm_rvalid_i) begin
                        ld_data_reg <= load_value;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A flushed instruction must not leave the FSM parked here.
                    if (!ctl_mem_valid_i || ctl_wb_allowin_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // MEM->WB register: capture the finished instruction when WB can take
    // it; a bubble is inserted whenever WB advances without new work.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_bus_reg   <= '0;
            wb_valid_reg <= 1'b0;
        end else if (transfer) begin
            wb_bus_reg   <= '{wdest:   ex.wdest,
                              we:      ex.we,
                              result:  mem_result,
                              dm_addr: ex.exe_result,
                              pc:      ex.pc};
            wb_valid_reg <= 1'b1;
        end else if (ctl_wb_allowin_i) begin
            wb_valid_reg <= 1'b0;
        end
    end

    // Request fields come straight from the held EXE->MEM register, so they
    // stay stable for as long as the FSM sits in REQ.
    assign in_req     = (state_reg == ST_REQ);
    assign dm_req_o   = in_req;
    assign dm_we_o    = (in_req && ex.is_store) ? lane_strobe : 4'b0000;
    assign dm_addr_o  = in_req ? {ex.exe_result[31:2], 2'b00} : '0;
    assign dm_wdata_o = in_req ? lane_wdata : '0;

    assign ctl_mem_allowin_o     = ~ctl_mem_valid_i | transfer;
    assign ctl_mem_over_o        = over;
    assign ctl_mem_dest_o        = ctl_mem_valid_i ? ex.wdest : '0;
    assign ctl_mem_pc_o          = ex.pc;
    assign ctl_mem_misalign_o    = ctl_mem_valid_i & misalign;
    assign forward_mem2id_data_o = over ? mem_result : '0;
    assign mem2wb_bus_o          = wb_bus_reg;
    assign ctl_wb_valid_o        = wb_valid_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level model of the
// expected memory request, stage result and WB bus contents.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk;
    logic         rst_i;
    logic [106:0] exe2mem_bus_ri;
    logic         ctl_mem_valid_i;
    logic         ctl_wb_allowin_i;
    logic         ctl_mem_allowin_o;
    logic         ctl_mem_over_o;
    logic [4:0]   ctl_mem_dest_o;
    logic [31:0]  ctl_mem_pc_o;
    logic         ctl_mem_misalign_o;
    logic [31:0]  forward_mem2id_data_o;
    logic [101:0] mem2wb_bus_o;
    logic         ctl_wb_valid_o;
    logic         dm_req_o;
    logic [3:0]   dm_we_o;
    logic [31:0]  dm_addr_o;
    logic [31:0]  dm_wdata_o;
    logic         dm_ready_i;
    logic         dm_rvalid_i;
    logic [31:0]  dm_rdata_i;

    int checks = 0;
    int errors = 0;

    // Current instruction as the model sees it.
    logic [4:0]  m_wdest;
    logic        m_we, m_ld, m_st, m_sign;
    logic [1:0]  m_size;
    logic [31:0] m_res, m_sd, m_pc, m_rdata;

    // What the DUT presented on its first request cycle.
    logic [3:0]  seen_we;
    logic [31:0] seen_wdata, seen_addr;

    assign exe2mem_bus_ri = {m_wdest, m_we, m_ld, m_st, m_size, m_sign, m_res, m_sd, m_pc};
    assign dm_rdata_i     = m_rdata;

    mem_stage dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .exe2mem_bus_ri        (exe2mem_bus_ri),
        .ctl_mem_valid_i       (ctl_mem_valid_i),
        .ctl_wb_allowin_i      (ctl_wb_allowin_i),
        .ctl_mem_allowin_o     (ctl_mem_allowin_o),
        .ctl_mem_over_o        (ctl_mem_over_o),
        .ctl_mem_dest_o        (ctl_mem_dest_o),
        .ctl_mem_pc_o          (ctl_mem_pc_o),
        .ctl_mem_misalign_o    (ctl_mem_misalign_o),
        .forward_mem2id_data_o (forward_mem2id_data_o),
        .mem2wb_bus_o          (mem2wb_bus_o),
        .ctl_wb_valid_o        (ctl_wb_valid_o),
        .dm_req_o              (dm_req_o),
        .dm_we_o               (dm_we_o),
        .dm_addr_o             (dm_addr_o),
        .dm_wdata_o            (dm_wdata_o),
        .dm_ready_i            (dm_ready_i),
        .dm_rvalid_i           (dm_rvalid_i),
        .dm_rdata_i            (dm_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic model_mis();
        int a;
        a = int'(m_res[1:0]);
        if (!(m_ld || m_st)) return 1'b0;
        if (m_size == 2'd1) return (a % 2) != 0;
        if (m_size == 2'd2) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strobe();
        int a;
        a = int'(m_res[1:0]);
        case (m_size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return (a >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata();
        case (m_size)
            2'd0:    return {4{m_sd[7:0]}};
            2'd1:    return {2{m_sd[15:0]}};
            default: return m_sd;
        endcase
    endfunction

    function automatic logic [31:0] model_result();
        int sh;
        int b;
        logic [31:0] v;
        if (!(m_ld || m_st)) return m_res;
        if (model_mis() || m_st) return 32'h0;
        sh = 8 * int'(m_res[1:0]);
        v  = m_rdata >> sh;
        if (m_size == 2'd0) begin
            b = int'(v & 32'hFF);
            if (m_sign && b >= 128) b = b - 256;
            return b;
        end
        if (m_size == 2'd1) begin
            b = int'(v & 32'hFFFF);
            if (m_sign && b >= 32768) b = b - 65536;
            return b;
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    logic        prev_req, prev_ready;
    logic [31:0] prev_addr;

    // Checks stage outputs against the model on every non-reset cycle.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_req = 1'b0;
        end else begin
            chk("dest", ctl_mem_dest_o, ctl_mem_valid_i ? m_wdest : 5'd0);
            chk("misalign", ctl_mem_misalign_o, ctl_mem_valid_i & model_mis());
            if (ctl_mem_valid_i && (!(m_ld || m_st) || model_mis())) begin
                chk("fast_over", ctl_mem_over_o, 1'b1);
                chk("fast_noreq", dm_req_o, 1'b0);
            end
            chk("forward", forward_mem2id_data_o, ctl_mem_over_o ? model_result() : 32'h0);
            chk("allowin", ctl_mem_allowin_o, !ctl_mem_valid_i || (ctl_mem_over_o && ctl_wb_allowin_i));
            if (ctl_mem_valid_i) chk("pc", ctl_mem_pc_o, m_pc);
            if (dm_req_o) begin
                chk("req_addr", dm_addr_o, {m_res[31:2], 2'b00});
                if (m_st) begin
                    chk("req_strobe", dm_we_o, model_strobe());
                    chk("req_wdata", dm_wdata_o, model_wdata());
                end else begin
                    chk("req_read_we", dm_we_o, 4'b0000);
                end
            end else begin
                chk("idle_we", dm_we_o, 4'b0000);
            end
            if (prev_req && !prev_ready) begin
                chk("req_hold", dm_req_o, 1'b1);
                chk("addr_hold", dm_addr_o, prev_addr);
            end
            prev_req   = dm_req_o;
            prev_ready = dm_ready_i;
            prev_addr  = dm_addr_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input logic [4:0] wd, input logic we, input logic ld, input logic st,
                          input logic [1:0] sz, input logic sg, input logic [31:0] res,
                          input logic [31:0] sd, input logic [31:0] pc, input logic [31:0] rd);
        m_wdest = wd; m_we = we; m_ld = ld; m_st = st; m_size = sz; m_sign = sg;
        m_res = res; m_sd = sd; m_pc = pc; m_rdata = rd;
    endtask

    // Runs the current instruction: ready after rd request cycles, rvalid vd
    // cycles after acceptance, WB stalled for hold cycles once finished.
    task automatic run_op(input string name, input int rd, input int vd, input int hold, input int exp_cyc);
        int cyc, req_cnt, acc_cyc;
        bit accepted, got_over;
        logic [101:0] exp_bus, prev_bus;
        exp_bus  = {m_wdest, m_we, model_result(), m_res, m_pc};
        ctl_mem_valid_i = 1'b1;
        cyc = 0; req_cnt = 0; acc_cyc = 0; accepted = 0; got_over = 0;
        while (!got_over && cyc < 40) begin
            #1;
            if (ctl_mem_over_o) begin
                got_over = 1;
            end else begin
                if (dm_req_o && !accepted) begin
                    if (req_cnt == 0) begin
                        seen_we = dm_we_o; seen_wdata = dm_wdata_o; seen_addr = dm_addr_o;
                    end
                    if (req_cnt == rd) begin
                        dm_ready_i = 1'b1;
                        accepted   = 1;
                        acc_cyc    = cyc;
                        if (m_ld && vd == 0) dm_rvalid_i = 1'b1;
                    end
                    req_cnt++;
                end else if (accepted && m_ld && vd > 0 && (cyc - acc_cyc) == vd) begin
                    dm_rvalid_i = 1'b1;
                end
                @(posedge clk); #1;
                dm_ready_i = 1'b0; dm_rvalid_i = 1'b0;
                cyc++;
            end
        end
        chk({name, "_over_cycle"}, cyc, exp_cyc);
        prev_bus = mem2wb_bus_o;
        for (int h = 0; h < hold; h++) begin
            ctl_wb_allowin_i = 1'b0;
            @(posedge clk); #2;
            chk({name, "_hold_over"}, ctl_mem_over_o, 1'b1);
            chk({name, "_hold_wbvalid"}, ctl_wb_valid_o, 1'b0);
            chk({name, "_hold_bus"}, mem2wb_bus_o, prev_bus);
            chk({name, "_hold_noreq"}, dm_req_o, 1'b0);
            chk({name, "_hold_allowin"}, ctl_mem_allowin_o, 1'b0);
        end
        ctl_wb_allowin_i = 1'b1;
        @(posedge clk); #1;
        chk({name, "_wb_valid"}, ctl_wb_valid_o, 1'b1);
        chk({name, "_wb_bus"}, mem2wb_bus_o, exp_bus);
        ctl_mem_valid_i = 1'b0;
    endtask

    initial begin
        int waited;
        rst_i = 1'b1; ctl_mem_valid_i = 1'b0; ctl_wb_allowin_i = 1'b1;
        dm_ready_i = 1'b0; dm_rvalid_i = 1'b0;
        seen_we = '0; seen_wdata = '0; seen_addr = '0;
        set_op(5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", dm_req_o, 1'b0);
        chk("rst_we", dm_we_o, 4'b0);
        chk("rst_addr", dm_addr_o, 32'h0);
        chk("rst_wdata", dm_wdata_o, 32'h0);
        chk("rst_wbvalid", ctl_wb_valid_o, 1'b0);
        chk("rst_bus", mem2wb_bus_o, 102'h0);
        chk("rst_over", ctl_mem_over_o, 1'b0);
        chk("rst_forward", forward_mem2id_data_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through
        set_op(5'd7, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 32'h1000, 32'h0);
        run_op("alu", 0, 0, 0, 0);
        chk("alu_lit_result", mem2wb_bus_o[95:64], 32'h1234_5678);
        chk("alu_lit_wdest", mem2wb_bus_o[101:97], 5'd7);

        // SB to byte 3
        set_op(5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h1004, 32'h0);
        run_op("sb", 0, 0, 0, 2);
        chk("sb_lit_we", seen_we, 4'b1000);
        chk("sb_lit_wdata", seen_wdata, 32'hABAB_ABAB);
        chk("sb_lit_addr", seen_addr, 32'h0000_0100);

        // LB signed, rvalid three cycles after acceptance
        set_op(5'd5, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 32'h1008, 32'h0000_8000);
        run_op("lb", 0, 3, 0, 5);
        chk("lb_lit_result", mem2wb_bus_o[95:64], 32'hFFFF_FF80);

        // LBU same address, rvalid together with ready
        set_op(5'd5, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 32'h100C, 32'h0000_8000);
        run_op("lbu", 0, 0, 0, 2);
        chk("lbu_lit_result", mem2wb_bus_o[95:64], 32'h0000_0080);

        // LH misaligned
        set_op(5'd9, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0201, 32'h0, 32'h1010, 32'hFFFF_FFFF);
        run_op("lh_mis", 0, 0, 0, 0);
        chk("lh_mis_lit_result", mem2wb_bus_o[95:64], 32'h0);

        // SW with 4 cycles of ready backpressure, then WB stalled 2 cycles
        set_op(5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h1014, 32'h0);
        run_op("sw_bp", 4, 0, 2, 6);
        chk("sw_lit_we", seen_we, 4'b1111);
        chk("sw_lit_wdata", seen_wdata, 32'hDEAD_BEEF);

        // LW, one wait for ready, data with ready
        set_op(5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, 32'h1018, 32'hCAFE_F00D);
        run_op("lw", 1, 0, 0, 3);
        chk("lw_lit_result", mem2wb_bus_o[95:64], 32'hCAFE_F00D);

        // LH signed from upper half
        set_op(5'd4, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h101C, 32'h8001_0000);
        run_op("lh", 0, 1, 0, 3);
        chk("lh_lit_result", mem2wb_bus_o[95:64], 32'hFFFF_8001);

        // SH to upper half
        set_op(5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0106, 32'h0000_1234, 32'h1020, 32'h0);
        run_op("sh", 0, 0, 0, 2);
        chk("sh_lit_we", seen_we, 4'b1100);
        chk("sh_lit_wdata", seen_wdata, 32'h1234_1234);
        chk("sh_lit_addr", seen_addr, 32'h0000_0104);

        // LHU from upper half
        set_op(5'd4, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h1024, 32'h8001_0000);
        run_op("lhu", 0, 0, 0, 2);
        chk("lhu_lit_result", mem2wb_bus_o[95:64], 32'h0000_8001);

        // SW misaligned
        set_op(5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'h5555_AAAA, 32'h1028, 32'h0);
        run_op("sw_mis", 0, 0, 0, 0);
        chk("sw_mis_lit_result", mem2wb_bus_o[95:64], 32'h0);

        // Reset while waiting for read data, then a stale rvalid
        set_op(5'd6, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'h102C, 32'h1122_3344);
        ctl_mem_valid_i = 1'b1;
        waited = 0;
        #1;
        while (!dm_req_o && waited < 10) begin
            @(posedge clk); #2;
            waited++;
        end
        chk("rstwait_req_seen", dm_req_o, 1'b1);
        dm_ready_i = 1'b1;
        @(posedge clk); #1;
        dm_ready_i = 1'b0;
        #1;
        chk("rstwait_in_wait_noreq", dm_req_o, 1'b0);
        chk("rstwait_in_wait_over", ctl_mem_over_o, 1'b0);
        rst_i = 1'b1; ctl_mem_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        m_rdata = 32'hFFFF_FFFF;
        dm_rvalid_i = 1'b1;
        @(posedge clk); #1;
        dm_rvalid_i = 1'b0;
        #1;
        chk("rstwait_req", dm_req_o, 1'b0);
        chk("rstwait_wbvalid", ctl_wb_valid_o, 1'b0);
        chk("rstwait_bus", mem2wb_bus_o, 102'h0);
        chk("rstwait_over", ctl_mem_over_o, 1'b0);
        @(posedge clk); #1;

        // FSM must be back in IDLE: a fresh SB takes the minimum time
        set_op(5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0100, 32'h0000_005A, 32'h1030, 32'h0);
        run_op("sb_after_rst", 0, 0, 0, 2);
        chk("sb2_lit_we", seen_we, 4'b0001);
        chk("sb2_lit_wdata", seen_wdata, 32'h5A5A_5A5A);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
